mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
- MEM stage of the 5-stage pipeline: sits between the EX/MEM latch and the MEM/WB latch.
- Issues data-memory read/write requests to the dcache and holds them until dhit.
- Stalls upstream while a request is outstanding.
- Registers the WB-bound result: write data, destination, control, halt, fault.

Parameters:
- ALIGN_CHECK, 1: when 1, word-misaligned accesses (addr[1:0]!=0) are suppressed and flagged.
- STALL_CNT_W, 32: width of the saturating stall-cycle counter.

Ports:
- CLK  in  1  core clock, rising edge.
- RST  in  1  reset, synchronous, active-high.
- ex_valid  in  1  EX/MEM latch holds a real instruction (0 = bubble).
- ex_dREN  in  1  load.
- ex_dWEN  in  1  store.
- ex_result  in  32  ALU result; this is the memory address for loads/stores.
- ex_store  in  32  store data (rdat2).
- ex_pc  in  32  instruction PC.
- ex_rf_write  in  1  instruction writes the register file.
- ex_wsel  in  5  destination register.
- ex_halt  in  1  halt instruction.
- dhit  in  1  dcache completes the current request this cycle.
- dmemload  in  32  load data, valid when dhit.
- dmemREN  out  1  read request.
- dmemWEN  out  1  write request.
- dmemaddr  out  32  request address.
- dmemstore  out  32  write data.
- mem_stall  out  1  upstream (PC, IF/ID, ID/EX, EX/MEM) must hold this cycle.
- wb_valid  out  1  WB latch holds a real instruction.
- wb_rf_write  out  1  WB writes the register file.
- wb_wsel  out  5  WB destination register.
- wb_wdat  out  32  WB write data.
- wb_pc  out  32  PC of the WB instruction.
- wb_halt  out  1  sticky halt.
- wb_fault  out  1  misaligned access flag for the WB instruction.
- stall_cnt  out  STALL_CNT_W  saturating count of mem_stall cycles.

Behaviour:
- Reset: all wb_* outputs, dmemREN, dmemWEN, dmemaddr, dmemstore, stall_cnt and mem_stall are 0. State is IDLE.
- While RST=1, dmemREN, dmemWEN and mem_stall are forced to 0 combinationally. Reset during REQ drops the request and discards the latched copy.
- FSM states:
  - IDLE:
    - Evaluates ex_*.
    - Memory op = ex_valid & (ex_dREN | ex_dWEN) & aligned.
    - Drives dmem* combinationally from ex_*.
    - dhit in the same cycle: completes at the edge, mem_stall=0.
    - No dhit: mem_stall=1. Latch addr, store data, ctrl, pc and wsel; go to REQ.
  - REQ:
    - Drives dmem* from the latched copy; ex_* is ignored.
    - mem_stall=1 until dhit.
    - Cycle with dhit: mem_stall=0, WB regs load at the edge, go to IDLE.
  - HALTED:
    - Entered on the edge where a valid ex_halt is accepted.
    - No requests, mem_stall=0, wb_valid=0.
    - wb_halt stays 1 until RST.
- Non-memory valid instruction: 1-cycle pass-through to the WB regs; wb_wdat = ex_result.
- Load: wb_wdat = dmemload captured on dhit.
- Store: wb_rf_write is forced to 0.
- ex_valid=0: wb_valid=0 on the next edge (bubble propagates). No request is issued.
- Request outputs are strictly one-hot: ex_dREN & ex_dWEN together are treated as a store (dmemREN=0).
- Misaligned access with ALIGN_CHECK=1:
  - No request is issued and there is no stall.
  - Next edge: wb_valid=1, wb_rf_write=0, wb_fault=1. wb_fault lasts one cycle.
- Halt carried on a memory op: the access completes first, then wb_halt=1.
- stall_cnt increments on each cycle with mem_stall=1 and saturates at all-ones.
- Latency:
  - Cache hit in the first cycle: 1 cycle EX/MEM to WB.
  - Otherwise: 1 + number of REQ cycles.

Decomposition:
- cpu_types_pkg gains:
  - memstage_state_t enum {IDLE, REQ, HALTED}.
  - Constant WORD_ALIGN_MASK = 2'b11.
  - word_t and regbits_t are reused from the same package.
- One sub-module, mem_access_wb_reg: the WB output register bank with load enable and bubble insert. The FSM, request muxing and counter stay in the top.

Test Plan:
- Load, dhit held low for 3 cycles, addr 0x100, dmemload 0xDEADBEEF, wsel 5:
  - mem_stall=1 for 3 cycles.
  - dmemaddr stays 0x100 even after ex_* changes.
  - Then wb_wdat=0xDEADBEEF, wb_wsel=5, wb_rf_write=1.
  - stall_cnt=3.
- Store with same-cycle dhit, addr 0x200, data 0x12345678:
  - dmemWEN=1, dmemstore=0x12345678, mem_stall=0.
  - Next cycle: wb_valid=1, wb_rf_write=0.
- ALU op, ex_result 0x55, then bubble:
  - wb_wdat=0x55, wb_valid=1.
  - Next cycle: wb_valid=0.
- Misaligned load at addr 0x102:
  - dmemREN never asserts.
  - wb_fault=1 for 1 cycle, wb_rf_write=0.
- Halt accepted:
  - wb_halt=1 and stays 1.
  - A following load presented on ex_* produces no dmemREN.
  - RST clears wb_halt.
- RST asserted in the 2nd cycle of REQ:
  - Next cycle: dmemREN=0, mem_stall=0, state IDLE, all wb_* = 0.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU types.
// Contents:
//   word_t           32-bit machine word
//   regbits_t        register-file index
//   memstage_state_t MEM-stage controller state
//   WORD_ALIGN_MASK  address bits that must be zero for a word access
package cpu_types_pkg;

  typedef logic [31:0] word_t;
  typedef logic [4:0]  regbits_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    HALTED
  } memstage_state_t;

  localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;

endpackage

// File: rtl/mem_access_wb_reg.sv
// MEM/WB output register bank.
// Each edge either loads a completed instruction (i_load=1) or inserts a
// bubble (valid, rf_write and fault cleared, payload held). Halt is sticky
// until reset.
// Ports:
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_load            a completed instruction enters WB this edge
//   i_rf_write..i_fault  payload of that instruction
//   o_valid..o_fault  registered WB outputs
module mem_access_wb_reg
  import cpu_types_pkg::*;
(
  input  logic     i_clk,
  input  logic     i_rst,
  input  logic     i_load,
  input  logic     i_rf_write,
  input  regbits_t i_wsel,
  input  word_t    i_wdat,
  input  word_t    i_pc,
  input  logic     i_halt,
  input  logic     i_fault,
  output logic     o_valid,
  output logic     o_rf_write,
  output regbits_t o_wsel,
  output word_t    o_wdat,
  output word_t    o_pc,
  output logic     o_halt,
  output logic     o_fault
);

  logic     r_valid;
  logic     r_rf_write;
  regbits_t r_wsel;
  word_t    r_wdat;
  word_t    r_pc;
  logic     r_halt;
  logic     r_fault;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid    <= 1'b0;
      r_rf_write <= 1'b0;
      r_wsel     <= '0;
      r_wdat     <= '0;
      r_pc       <= '0;
      r_halt     <= 1'b0;
      r_fault    <= 1'b0;
    end else if (i_load) begin
      r_valid    <= 1'b1;
      r_rf_write <= i_rf_write;
      r_wsel     <= i_wsel;
      r_wdat     <= i_wdat;
      r_pc       <= i_pc;
      r_halt     <= r_halt | i_halt;
      r_fault    <= i_fault;
    end else begin
      r_valid    <= 1'b0;
      r_rf_write <= 1'b0;
      r_fault    <= 1'b0;
    end
  end

  assign o_valid    = r_valid;
  assign o_rf_write = r_rf_write;
  assign o_wsel     = r_wsel;
  assign o_wdat     = r_wdat;
  assign o_pc       = r_pc;
  assign o_halt     = r_halt;
  assign o_fault    = r_fault;

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues dcache requests, holds them until dhit, stalls
// upstream while a request is outstanding and registers the WB-bound result.
// Ports:
//   CLK, RST                      clock, synchronous active-high reset
//   ex_*                          EX/MEM latch contents
//   dhit, dmemload                dcache completion and load data
//   dmemREN/WEN/addr/store        dcache request (one-hot REN/WEN)
//   mem_stall                     hold upstream stages this cycle
//   wb_*                          MEM/WB latch contents
//   stall_cnt                     saturating count of stall cycles
module mem_access_stage
  import cpu_types_pkg::*;
#(
  parameter bit          ALIGN_CHECK = 1'b1,
  parameter int unsigned STALL_CNT_W = 32
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   ex_valid,
  input  logic                   ex_dREN,
  input  logic                   ex_dWEN,
  input  word_t                  ex_result,
  input  word_t                  ex_store,
  input  word_t                  ex_pc,
  input  logic                   ex_rf_write,
  input  regbits_t               ex_wsel,
  input  logic                   ex_halt,
  input  logic                   dhit,
  input  word_t                  dmemload,
  output logic                   dmemREN,
  output logic                   dmemWEN,
  output word_t                  dmemaddr,
  output word_t                  dmemstore,
  output logic                   mem_stall,
  output logic                   wb_valid,
  output logic                   wb_rf_write,
  output regbits_t               wb_wsel,
  output word_t                  wb_wdat,
  output word_t                  wb_pc,
  output logic                   wb_halt,
  output logic                   wb_fault,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  localparam logic [STALL_CNT_W-1:0] CntOne = {{(STALL_CNT_W-1){1'b0}}, 1'b1};

  memstage_state_t r_state;

  // Copy of the outstanding request, owned by REQ.
  logic     r_ren;
  logic     r_wen;
  word_t    r_addr;
  word_t    r_store;
  word_t    r_pc;
  regbits_t r_wsel;
  logic     r_rf_write;
  logic     r_halt;

  logic [STALL_CNT_W-1:0] r_stall_cnt;

  logic     w_aligned;
  logic     w_is_mem;
  logic     w_mem_op;
  logic     w_fault;
  logic     w_ren;
  logic     w_wen;
  word_t    w_addr;
  word_t    w_sdata;
  logic     w_stall;
  logic     w_wb_load;
  logic     w_wb_rf_write;
  regbits_t w_wb_wsel;
  word_t    w_wb_wdat;
  word_t    w_wb_pc;
  logic     w_wb_halt;
  logic     w_wb_fault;

  always_comb begin
    w_aligned = !ALIGN_CHECK || ((ex_result[1:0] & WORD_ALIGN_MASK) == 2'b00);
    w_is_mem  = ex_valid & (ex_dREN | ex_dWEN);
    w_mem_op  = w_is_mem & w_aligned;
    w_fault   = w_is_mem & ~w_aligned;

    w_ren         = 1'b0;
    w_wen         = 1'b0;
    w_addr        = ex_result;
    w_sdata       = ex_store;
    w_wb_load     = 1'b0;
    w_wb_rf_write = 1'b0;
    w_wb_wsel     = ex_wsel;
    w_wb_wdat     = ex_result;
    w_wb_pc       = ex_pc;
    w_wb_halt     = 1'b0;
    w_wb_fault    = 1'b0;

    case (r_state)
      IDLE: begin
        // Store wins when both enables are set, keeping requests one-hot.
        w_ren = w_mem_op & ex_dREN & ~ex_dWEN;
        w_wen = w_mem_op & ex_dWEN;
      end
      REQ: begin
        w_ren   = r_ren;
        w_wen   = r_wen;
        w_addr  = r_addr;
        w_sdata = r_store;
      end
      default: ;
    endcase

    if (RST) begin
      w_ren = 1'b0;
      w_wen = 1'b0;
    end

    w_stall = (w_ren | w_wen) & ~dhit;

    case (r_state)
      IDLE: begin
        w_wb_load     = ex_valid & ~w_stall;
        w_wb_rf_write = ex_rf_write & ~ex_dWEN & ~w_fault;
        w_wb_wdat     = w_ren ? dmemload : ex_result;
        w_wb_halt     = ex_halt;
        w_wb_fault    = w_fault;
      end
      REQ: begin
        w_wb_load     = dhit;
        w_wb_rf_write = r_rf_write;
        w_wb_wsel     = r_wsel;
        w_wb_wdat     = r_ren ? dmemload : r_addr;
        w_wb_pc       = r_pc;
        w_wb_halt     = r_halt;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= IDLE;
      r_ren       <= 1'b0;
      r_wen       <= 1'b0;
      r_addr      <= '0;
      r_store     <= '0;
      r_pc        <= '0;
      r_wsel      <= '0;
      r_rf_write  <= 1'b0;
      r_halt      <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      if (w_stall && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CntOne;
      end
      case (r_state)
        IDLE: begin
          if (w_stall) begin
            r_ren      <= w_ren;
            r_wen      <= w_wen;
            r_addr     <= ex_result;
            r_store    <= ex_store;
            r_pc       <= ex_pc;
            r_wsel     <= ex_wsel;
            r_rf_write <= ex_rf_write & ~ex_dWEN;
            r_halt     <= ex_halt;
            r_state    <= REQ;
          end else if (w_wb_load && ex_halt) begin
            r_state <= HALTED;
          end
        end
        REQ: begin
          if (dhit) begin
            r_state <= r_halt ? HALTED : IDLE;
          end
        end
        HALTED:  r_state <= HALTED;
        default: r_state <= IDLE;
      endcase
    end
  end

  mem_access_wb_reg u_wb_reg (
    .i_clk      (CLK),
    .i_rst      (RST),
    .i_load     (w_wb_load),
    .i_rf_write (w_wb_rf_write),
    .i_wsel     (w_wb_wsel),
    .i_wdat     (w_wb_wdat),
    .i_pc       (w_wb_pc),
    .i_halt     (w_wb_halt),
    .i_fault    (w_wb_fault),
    .o_valid    (wb_valid),
    .o_rf_write (wb_rf_write),
    .o_wsel     (wb_wsel),
    .o_wdat     (wb_wdat),
    .o_pc       (wb_pc),
    .o_halt     (wb_halt),
    .o_fault    (wb_fault)
  );

  // Address and store data read as zero when no request is active.
  assign dmemREN   = w_ren;
  assign dmemWEN   = w_wen;
  assign dmemaddr  = (w_ren | w_wen) ? w_addr : '0;
  assign dmemstore = w_wen ? w_sdata : '0;
  assign mem_stall = w_stall;
  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;

  logic        CLK = 1'b0;
  logic        RST;
  logic        ex_valid, ex_dREN, ex_dWEN, ex_rf_write, ex_halt;
  logic [31:0] ex_result, ex_store, ex_pc;
  logic [4:0]  ex_wsel;
  logic        dhit;
  logic [31:0] dmemload;
  logic        dmemREN, dmemWEN, mem_stall;
  logic [31:0] dmemaddr, dmemstore;
  logic        wb_valid, wb_rf_write, wb_halt, wb_fault;
  logic [4:0]  wb_wsel;
  logic [31:0] wb_wdat, wb_pc;
  logic [31:0] stall_cnt;

  int n_total = 0;
  int n_pass  = 0;
  bit chk_en  = 1'b0;

  always #5 CLK = ~CLK;

  mem_access_stage #(
    .ALIGN_CHECK (1'b1),
    .STALL_CNT_W (32)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .ex_valid    (ex_valid),
    .ex_dREN     (ex_dREN),
    .ex_dWEN     (ex_dWEN),
    .ex_result   (ex_result),
    .ex_store    (ex_store),
    .ex_pc       (ex_pc),
    .ex_rf_write (ex_rf_write),
    .ex_wsel     (ex_wsel),
    .ex_halt     (ex_halt),
    .dhit        (dhit),
    .dmemload    (dmemload),
    .dmemREN     (dmemREN),
    .dmemWEN     (dmemWEN),
    .dmemaddr    (dmemaddr),
    .dmemstore   (dmemstore),
    .mem_stall   (mem_stall),
    .wb_valid    (wb_valid),
    .wb_rf_write (wb_rf_write),
    .wb_wsel     (wb_wsel),
    .wb_wdat     (wb_wdat),
    .wb_pc       (wb_pc),
    .wb_halt     (wb_halt),
    .wb_fault    (wb_fault),
    .stall_cnt   (stall_cnt)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic        ren, wen, rf_write, halt;
    logic [31:0] addr, store, pc;
    logic [4:0]  wsel;
  } instr_t;

  bit          m_pending = 0;   // an access is waiting for dhit
  instr_t      m_req;
  bit          m_halted = 0;
  logic        m_valid = 0, m_rfw = 0, m_halt = 0, m_fault = 0;
  logic [4:0]  m_wsel = 0;
  logic [31:0] m_wdat = 0, m_pc = 0, m_cnt = 0;

  always @(negedge CLK) begin
    if (chk_en) begin
      instr_t cur;
      bit have, mis, access;
      logic e_ren, e_wen, e_stall;
      logic [31:0] e_addr, e_store;
      cur = '{default: '0};
      have = 0;
      if (!RST && !m_halted) begin
        if (m_pending) begin
          cur = m_req; have = 1;
        end else if (ex_valid) begin
          cur.ren = ex_dREN; cur.wen = ex_dWEN; cur.rf_write = ex_rf_write;
          cur.halt = ex_halt; cur.addr = ex_result; cur.store = ex_store;
          cur.pc = ex_pc; cur.wsel = ex_wsel; have = 1;
        end
      end
      mis    = have && (cur.ren || cur.wen) && (cur.addr % 4 != 0);
      access = have && (cur.ren || cur.wen) && !mis;
      e_wen   = access && cur.wen;
      e_ren   = access && cur.ren && !cur.wen;
      e_addr  = access ? cur.addr : 32'h0;
      e_store = e_wen ? cur.store : 32'h0;
      e_stall = access && !dhit;

      chk("dmemREN", dmemREN, e_ren);
      chk("dmemWEN", dmemWEN, e_wen);
      chk("dmemaddr", dmemaddr, e_addr);
      chk("dmemstore", dmemstore, e_store);
      chk("mem_stall", mem_stall, e_stall);
      chk("wb_valid", wb_valid, m_valid);
      chk("wb_rf_write", wb_rf_write, m_rfw);
      chk("wb_wsel", wb_wsel, m_wsel);
      chk("wb_wdat", wb_wdat, m_wdat);
      chk("wb_pc", wb_pc, m_pc);
      chk("wb_halt", wb_halt, m_halt);
      chk("wb_fault", wb_fault, m_fault);
      chk("stall_cnt", stall_cnt, m_cnt);

      // state after the coming edge
      if (RST) begin
        m_pending = 0; m_halted = 0; m_cnt = 0;
        m_valid = 0; m_rfw = 0; m_halt = 0; m_fault = 0;
        m_wsel = 0; m_wdat = 0; m_pc = 0;
      end else begin
        if (e_stall && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
        if (e_stall) begin
          if (!m_pending) begin m_pending = 1; m_req = cur; end
          m_valid = 0; m_rfw = 0; m_fault = 0;
        end else if (have) begin
          m_valid = 1;
          m_rfw   = cur.rf_write && !cur.wen && !mis;
          m_wsel  = cur.wsel;
          m_pc    = cur.pc;
          m_wdat  = e_ren ? dmemload : cur.addr;
          m_fault = mis;
          if (cur.halt) begin m_halt = 1; m_halted = 1; end
          m_pending = 0;
        end else begin
          m_valid = 0; m_rfw = 0; m_fault = 0;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_ex(input logic v, input logic ren, input logic wen, input logic [31:0] res,
                        input logic [31:0] st, input logic [31:0] pc, input logic rfw,
                        input logic [4:0] wsel, input logic halt);
    ex_valid = v; ex_dREN = ren; ex_dWEN = wen; ex_result = res; ex_store = st;
    ex_pc = pc; ex_rf_write = rfw; ex_wsel = wsel; ex_halt = halt;
  endtask

  task automatic bubble();
    set_ex(0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 5'd0, 0);
  endtask

  initial begin
    RST = 1'b1; bubble(); dhit = 0; dmemload = 0;
    cyc();
    chk_en = 1'b1;
    cyc();
    @(negedge CLK);
    chk("rst wb_valid", wb_valid, 0);
    chk("rst wb_halt", wb_halt, 0);
    chk("rst stall_cnt", stall_cnt, 0);
    chk("rst mem_stall", mem_stall, 0);
    cyc(); RST = 1'b0;

    // Load with three miss cycles
    set_ex(1, 1, 0, 32'h100, 32'h0, 32'h1000, 1, 5'd5, 0); dhit = 0;
    @(negedge CLK);
    chk("ld stall c1", mem_stall, 1);
    chk("ld addr c1", dmemaddr, 32'h100);
    cyc(); set_ex(1, 0, 1, 32'h300, 32'hAAAA, 32'h1004, 0, 5'd9, 0);
    @(negedge CLK);
    chk("ld stall c2", mem_stall, 1);
    chk("ld addr held c2", dmemaddr, 32'h100);
    chk("ld ren c2", dmemREN, 1);
    chk("ld wen c2", dmemWEN, 0);
    cyc();
    @(negedge CLK);
    chk("ld stall c3", mem_stall, 1);
    chk("ld addr held c3", dmemaddr, 32'h100);
    cyc(); dhit = 1; dmemload = 32'hDEADBEEF;
    @(negedge CLK);
    chk("ld stall hit", mem_stall, 0);

    // Store hitting in its first cycle
    cyc(); set_ex(1, 0, 1, 32'h200, 32'h12345678, 32'h1008, 0, 5'd0, 0); dmemload = 0;
    @(negedge CLK);
    chk("ld wb_wdat", wb_wdat, 32'hDEADBEEF);
    chk("ld wb_wsel", wb_wsel, 5);
    chk("ld wb_rf_write", wb_rf_write, 1);
    chk("ld wb_valid", wb_valid, 1);
    chk("ld stall_cnt", stall_cnt, 3);
    chk("st wen", dmemWEN, 1);
    chk("st data", dmemstore, 32'h12345678);
    chk("st stall", mem_stall, 0);

    // ALU op then bubble
    cyc(); set_ex(1, 0, 0, 32'h55, 32'h0, 32'h100C, 1, 5'd7, 0); dhit = 0;
    @(negedge CLK);
    chk("st wb_valid", wb_valid, 1);
    chk("st wb_rf_write", wb_rf_write, 0);
    cyc(); bubble();
    @(negedge CLK);
    chk("alu wb_wdat", wb_wdat, 32'h55);
    chk("alu wb_valid", wb_valid, 1);
    chk("alu wb_rf_write", wb_rf_write, 1);

    // Misaligned load
    cyc(); set_ex(1, 1, 0, 32'h102, 32'h0, 32'h1010, 1, 5'd3, 0);
    @(negedge CLK);
    chk("mis ren", dmemREN, 0);
    chk("mis stall", mem_stall, 0);
    chk("bubble wb_valid", wb_valid, 0);
    cyc(); bubble();
    @(negedge CLK);
    chk("mis wb_fault", wb_fault, 1);
    chk("mis wb_rf_write", wb_rf_write, 0);
    chk("mis wb_valid", wb_valid, 1);

    // REN and WEN together behave as a store
    cyc(); set_ex(1, 1, 1, 32'h40, 32'h77, 32'h1014, 1, 5'd4, 0); dhit = 1;
    @(negedge CLK);
    chk("mis fault 1cyc", wb_fault, 0);
    chk("both ren", dmemREN, 0);
    chk("both wen", dmemWEN, 1);
    cyc(); bubble(); dhit = 0;
    @(negedge CLK);
    chk("both wb_rf_write", wb_rf_write, 0);

    // Reset in the second REQ cycle
    cyc(); set_ex(1, 1, 0, 32'h80, 32'h0, 32'h1018, 1, 5'd6, 0);
    cyc();
    cyc(); RST = 1'b1;
    @(negedge CLK);
    chk("rstreq ren", dmemREN, 0);
    chk("rstreq stall", mem_stall, 0);
    cyc(); RST = 1'b0; bubble();
    @(negedge CLK);
    chk("rstreq ren after", dmemREN, 0);
    chk("rstreq stall after", mem_stall, 0);
    chk("rstreq wb_valid", wb_valid, 0);
    chk("rstreq wb_wdat", wb_wdat, 0);
    chk("rstreq wb_pc", wb_pc, 0);
    chk("rstreq wb_wsel", wb_wsel, 0);
    chk("rstreq stall_cnt", stall_cnt, 0);
    cyc(); set_ex(1, 1, 0, 32'h84, 32'h0, 32'h101C, 1, 5'd1, 0);
    dhit = 1; dmemload = 32'h11112222;
    @(negedge CLK);
    chk("idle after rst ren", dmemREN, 1);
    chk("idle after rst addr", dmemaddr, 32'h84);

    // Plain halt
    cyc(); set_ex(1, 0, 0, 32'h9, 32'h0, 32'h2000, 0, 5'd0, 1); dhit = 0;
    cyc(); set_ex(1, 1, 0, 32'h10, 32'h0, 32'h2004, 1, 5'd2, 0); dhit = 1;
    @(negedge CLK);
    chk("halt wb_halt", wb_halt, 1);
    chk("halt no ren", dmemREN, 0);
    cyc();
    @(negedge CLK);
    chk("halted wb_valid", wb_valid, 0);
    chk("halted stall", mem_stall, 0);
    cyc(); cyc();
    @(negedge CLK);
    chk("halt sticky", wb_halt, 1);
    chk("halted no ren", dmemREN, 0);
    cyc(); RST = 1'b1;
    cyc(); RST = 1'b0; bubble(); dhit = 0;
    @(negedge CLK);
    chk("rst clears halt", wb_halt, 0);

    // Halt riding on a load that misses once
    cyc(); set_ex(1, 1, 0, 32'h20, 32'h0, 32'h3000, 1, 5'd8, 1);
    @(negedge CLK);
    chk("hld stall", mem_stall, 1);
    cyc(); dhit = 1; dmemload = 32'hCAFE0001;
    @(negedge CLK);
    chk("hld halt pending", wb_halt, 0);
    cyc(); set_ex(1, 1, 0, 32'h24, 32'h0, 32'h3004, 1, 5'd9, 0); dmemload = 0;
    @(negedge CLK);
    chk("hld wb_halt", wb_halt, 1);
    chk("hld wb_wdat", wb_wdat, 32'hCAFE0001);
    chk("hld wb_wsel", wb_wsel, 8);
    chk("hld no ren", dmemREN, 0);
    cyc();
    @(negedge CLK);
    chk("hld still no ren", dmemREN, 0);

    cyc(); RST = 1'b1;
    cyc(); cyc();
    @(negedge CLK);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
